// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encoding, FSM states and op decode helpers.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for the sign corrections of products, quotients and remainders.
module mdu_cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] x_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply (radix-2 shift-add) and divide
// (restoring shift-subtract) engine feeding the HI/LO registers.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state_q;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     opd_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sgnq_q;
    logic                 sgnr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dz_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 op_div;
    logic                 op_sgn;
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shl;
    logic [WIDTH+1:0]     div_sub;
    logic                 div_ok;

    assign op_div = op_is_div(op_q);
    assign op_sgn = op_is_signed(op_q);
    assign neg_a  = op_sgn & a_q[WIDTH-1];
    assign neg_b  = op_sgn & b_q[WIDTH-1];

    // The unsigned magnitude of the most-negative value is exact in WIDTH bits.
    mdu_cond_neg #(.W(WIDTH)) u_mag_a (
        .x_i   (a_q),
        .neg_i (neg_a),
        .y_o   (mag_a)
    );

    mdu_cond_neg #(.W(WIDTH)) u_mag_b (
        .x_i   (b_q),
        .neg_i (neg_b),
        .y_o   (mag_b)
    );

    mdu_cond_neg #(.W(2*WIDTH)) u_fix_prod (
        .x_i   (acc_q),
        .neg_i (sgnq_q),
        .y_o   (prod_fix)
    );

    mdu_cond_neg #(.W(WIDTH)) u_fix_quo (
        .x_i   (acc_q[WIDTH-1:0]),
        .neg_i (sgnq_q),
        .y_o   (quo_fix)
    );

    mdu_cond_neg #(.W(WIDTH)) u_fix_rem (
        .x_i   (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i (sgnr_q),
        .y_o   (rem_fix)
    );

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        acc_d   = acc_q;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_shl = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_sub = {1'b0, div_shl} - {2'b00, opd_q};
        div_ok  = ~div_sub[WIDTH+1] & ~div_sub[WIDTH];
        if (op_div) begin
            acc_d[2*WIDTH-1:WIDTH] = div_ok ? div_sub[WIDTH-1:0]
                                            : div_shl[WIDTH-1:0];
            acc_d[WIDTH-1:0]       = {acc_q[WIDTH-2:0], div_ok};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= PREP;
                    end
                end
                PREP: begin
                    sgnq_q <= neg_a ^ neg_b;
                    sgnr_q <= neg_a;
                    if (op_div && (b_q == '0)) begin
                        hi_q    <= a_q;
                        lo_q    <= '1;
                        done_q  <= 1'b1;
                        dz_q    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= CNT_W'(WIDTH);
                        opd_q   <= op_div ? mag_b : mag_a;
                        acc_q   <= {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (op_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
